hv_bundler: RTL and testbench
=============================

# hv_bundler

Majority-vote bundling stage that consumes the dimension-grouped feature bits produced by the encoder net-rearrangement stage and produces the binary query hypervector. For each of `HV_DIM` dimensions it counts the ones across `FEATURE_COUNT` level/shifted HV bits and sets the output bit if the count reaches the majority threshold. Dimensions are processed `LANES` at a time over multiple cycles, which bounds the popcount area. The result feeds the associative-memory/similarity stage.

## Interface
- `HV_DIM`, 4096: hypervector dimensionality.
- `FEATURE_COUNT`, 617: bits bundled per dimension.
- `LANES`, 64: dimensions processed per cycle. Must divide `HV_DIM`.
- `MAJ_THRESH`, `FEATURE_COUNT/2 + 1` (309): an output bit is 1 iff popcount ≥ `MAJ_THRESH`.
- `clk`, in, 1: single clock, rising edge.
- `nrst`, in, 1: asynchronous, active-low reset.
- `bits_to_bundle_arr`, in, `[FEATURE_COUNT-1:0]` × `[0:HV_DIM-1]`: per-dimension feature bits. Must be held stable from the `start` edge until `hv_valid`.
- `start`, in, 1: begin bundling. Sampled only in IDLE or DONE.
- `busy`, out, 1: high in RUN and FLUSH.
- `hv_valid`, out, 1: query HV is complete and held.
- `hv_ready`, in, 1: consumer accepts the HV.
- `query_hv`, out, `[HV_DIM-1:0]`: bundled hypervector. Bit j corresponds to dimension j.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - `start=1` → RUN, `chunk_idx←0`.
  - `query_hv` retains its previous value.
- RUN:
  - Each cycle, dimensions `chunk_idx*LANES … chunk_idx*LANES+LANES-1` are popcounted.
  - The counts are registered into `cnt_q[LANES]` together with `wr_idx←chunk_idx` and `wr_en←1`.
  - `chunk_idx` increments each cycle.
  - When `chunk_idx == NUM_CHUNKS-1` (63), the next state is FLUSH.
- Write-back, in every cycle where `wr_en=1`: `query_hv[wr_idx*LANES + k] ← (cnt_q[k] ≥ MAJ_THRESH)` for each lane k. This happens independent of state.
- FLUSH: one cycle, lets the last chunk write back. Next state is DONE and `hv_valid←1` on the same edge.
- DONE:
  - `hv_valid` stays high and `query_hv` stays stable until `hv_valid && hv_ready`.
  - On handshake: if `start=1` in the same cycle → RUN (back-to-back), otherwise → IDLE. Either way `hv_valid←0`.
  - `start` in DONE without `hv_ready` is ignored.
- `start` in RUN or FLUSH is ignored; no queuing.
- Width rules:
  - `CNT_W = $clog2(FEATURE_COUNT+1)` = 10. Popcount cannot overflow.
  - The comparison is unsigned.
  - `FEATURE_COUNT` is odd, so no tie-break is needed. If it is ever even, a count equal to `FEATURE_COUNT/2` yields 0.
- `chunk_idx` width: `$clog2(NUM_CHUNKS)`, with `NUM_CHUNKS = HV_DIM/LANES`. It wraps to 0 only via the next `start`.

## Timing
- Reset (`nrst=0`, asynchronous): state=IDLE, `chunk_idx=0`, `wr_en=0`, `cnt_q=0`, `busy=0`, `hv_valid=0`, `query_hv='0`.
- Latency: with `start` sampled at edge E0, `hv_valid` rises at edge E(`NUM_CHUNKS`+1) = E65.
- Throughput: one HV per 66 cycles when `hv_ready` is tied high and `start` is held.
- `busy` is registered. It rises at E0 and falls at E65, the same edge `hv_valid` rises.
- Reset mid-operation aborts immediately. There is no partial `hv_valid`, and `query_hv` is cleared.
- Critical path: a 617-input popcount tree followed by the `cnt_q` register. The compare is in the following stage.

## Structure
- Shared package `hdc_pkg`: `HV_DIM`, `FEATURE_COUNT`, `LANES`, `NUM_CHUNKS`, `CNT_W`, `MAJ_THRESH`, and the state enum `bundler_state_e`. These are shared with the encoder and similarity stages.
- Sub-module `hv_popcount`: purely combinational, `FEATURE_COUNT`-bit input, `CNT_W`-bit output, adder tree. Instantiated `LANES` times via generate.
- Chunk selection: an indexed part-select on `bits_to_bundle_arr` by `chunk_idx*LANES`. No input buffering.

## Test plan
- All inputs 0, `start` pulse → `hv_valid` at cycle 65, `query_hv` = all 0; `busy` high cycles 1–64.
- All inputs 1 → `query_hv` = all 1.
- Threshold boundary: dim 0 has 309 ones → bit 0 = 1; dim 1 has 308 ones → bit 1 = 0; dim 4095 has 617 ones → 1; dim 64 (first lane of chunk 1) has 309 ones → 1.
- Random 617×4096 vectors versus a reference-model popcount/majority → bit-exact match on 20 vectors, with `hv_ready` high back-to-back → a new `hv_valid` every 66 cycles.
- Backpressure: `hv_ready=0` for 10 cycles after `hv_valid` → `query_hv` stable and `start` ignored; `hv_ready=1` → `hv_valid` drops next edge.
- `start` pulsed at cycle 30 of RUN → ignored, `hv_valid` still at cycle 65. `nrst` low at cycle 40 → all outputs 0 immediately, FSM IDLE, and a new `start` completes normally.

Source files
------------

// File: rtl/hdc_pkg.sv
// hdc_pkg: dimensions, widths and FSM states shared by the encoder, bundler and similarity stages
package hdc_pkg;
  localparam int HV_DIM        = 4096;
  localparam int FEATURE_COUNT = 617;
  localparam int LANES         = 64;
  localparam int NUM_CHUNKS    = HV_DIM / LANES;
  localparam int CNT_W         = $clog2(FEATURE_COUNT + 1);
  localparam int MAJ_THRESH    = FEATURE_COUNT / 2 + 1;
  localparam int IDX_W         = $clog2(NUM_CHUNKS);
  localparam int DIM_W         = $clog2(HV_DIM);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} bundler_state_e;
endpackage

// File: rtl/hv_popcount.sv
// hv_popcount: combinational ones-count of one dimension's feature bits as a balanced adder tree
module hv_popcount
  import hdc_pkg::*;
(
  input  logic [FEATURE_COUNT-1:0] bits,
  output logic [CNT_W-1:0]         cnt
);
  logic [CNT_W-1:0] s [FEATURE_COUNT];
  always_comb begin
    for (int i = 0; i < FEATURE_COUNT; i++) s[i] = CNT_W'(bits[i]);
    for (int st = 1; st < FEATURE_COUNT; st *= 2)
      for (int i = 0; i + st < FEATURE_COUNT; i += 2 * st) s[i] = s[i] + s[i + st];
    cnt = s[0];
  end
endmodule

// File: rtl/hv_bundler.sv
// hv_bundler: majority-vote bundling of per-dimension feature bits into the query hypervector, LANES dims per cycle
module hv_bundler
  import hdc_pkg::*;
(
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [FEATURE_COUNT-1:0] bits_to_bundle_arr [HV_DIM],
  input  logic                     start,
  output logic                     busy,
  output logic                     hv_valid,
  input  logic                     hv_ready,
  output logic [HV_DIM-1:0]        query_hv
);
  bundler_state_e             state;
  logic [IDX_W-1:0]           chunk_idx, wr_idx;
  logic                       wr_en;
  logic [LANES-1:0][CNT_W-1:0] cnt_d, cnt_q;
  logic [LANES-1:0]           maj;
  logic [DIM_W-1:0]           base, wr_base;
  assign base    = DIM_W'(chunk_idx) * DIM_W'(LANES);
  assign wr_base = DIM_W'(wr_idx) * DIM_W'(LANES);
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    hv_popcount u_pc (.bits(bits_to_bundle_arr[base + DIM_W'(k)]), .cnt(cnt_d[k]));
    assign maj[k] = cnt_q[k] >= CNT_W'(MAJ_THRESH);
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state     <= IDLE;
      chunk_idx <= '0;
      wr_idx    <= '0;
      wr_en     <= 1'b0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      hv_valid  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= RUN;
          chunk_idx <= '0;
          busy      <= 1'b1;
        end
        RUN: begin
          cnt_q  <= cnt_d;
          wr_idx <= chunk_idx;
          wr_en  <= 1'b1;
          if (chunk_idx == IDX_W'(NUM_CHUNKS - 1)) state <= FLUSH;
          else chunk_idx <= chunk_idx + 1'b1;
        end
        FLUSH: begin
          state    <= DONE;
          hv_valid <= 1'b1;
          busy     <= 1'b0;
        end
        DONE: if (hv_ready) begin
          hv_valid  <= 1'b0;
          state     <= start ? RUN : IDLE;
          chunk_idx <= start ? '0 : chunk_idx;
          busy      <= start;
        end
        default: state <= IDLE;
      endcase
    end
  // write-back trails the count register by one cycle, hence the FLUSH state
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) query_hv <= '0;
    else if (wr_en) query_hv[wr_base +: LANES] <= maj;
endmodule

// File: tb/tb_hv_bundler.sv
// tb_hv_bundler: directed threshold table, protocol corner sequences and random vectors against a popcount model
module tb_hv_bundler;
  import hdc_pkg::*;
  localparam int THR = FEATURE_COUNT / 2 + 1;
  logic clk = 0, nrst = 0, start = 0, hv_ready = 0;
  logic busy, hv_valid;
  logic [FEATURE_COUNT-1:0] arr [HV_DIM];
  logic [HV_DIM-1:0] query_hv, exp_hv, held;
  int n_cmp = 0, n_bad = 0, cyc = 0, lat, prev, g;
  typedef struct {int dim; int ones; logic exp;} vec_t;
  vec_t tbl [8];

  hv_bundler dut (
    .clk(clk), .nrst(nrst), .bits_to_bundle_arr(arr), .start(start),
    .busy(busy), .hv_valid(hv_valid), .hv_ready(hv_ready), .query_hv(query_hv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic chk_hv(input string name, input logic [HV_DIM-1:0] act, input logic [HV_DIM-1:0] req);
    int diff = 0, first = -1;
    for (int j = 0; j < HV_DIM; j++)
      if (act[j] !== req[j]) begin
        diff++;
        if (first < 0) first = j;
      end
    n_cmp++;
    if (diff != 0) begin
      n_bad++;
      $display("FAIL %s: %0d bits differ, first at dim %0d (got %b want %b)", name, diff, first, act[first], req[first]);
    end
  endtask

  function automatic logic [HV_DIM-1:0] model();
    logic [HV_DIM-1:0] m;
    for (int j = 0; j < HV_DIM; j++) m[j] = $countones(arr[j]) >= THR;
    return m;
  endfunction

  task automatic fill(input int mode);
    logic [639:0] t;
    for (int j = 0; j < HV_DIM; j++) begin
      for (int w = 0; w < 20; w++) t[w*32 +: 32] = $urandom;
      arr[j] = (mode == 0) ? '0 : (mode == 1) ? '1 : t[FEATURE_COUNT-1:0];
    end
  endtask

  task automatic do_run(input int poke_at, input int abort_at, output int l);
    int bad = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    l = 0;
    while (!hv_valid && l < 200) begin
      if (busy !== 1'b1) bad++;
      start = (l == poke_at);
      if (l == abort_at) begin
        nrst = 0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort valid", hv_valid, 0);
        chk_hv("abort query", query_hv, '0);
        l = -1;
        return;
      end
      @(negedge clk); l++;
    end
    start = 0;
    chk("busy window", bad, 0);
    chk("busy low at valid", busy, 0);
  endtask

  task automatic handshake();
    hv_ready = 1;
    @(negedge clk);
    chk("valid drop", hv_valid, 0);
    hv_ready = 0;
  endtask

  initial begin
    tbl[0] = '{0, 309, 1'b1};
    tbl[1] = '{1, 308, 1'b0};
    tbl[2] = '{4095, 617, 1'b1};
    tbl[3] = '{64, 309, 1'b1};
    tbl[4] = '{63, 310, 1'b1};
    tbl[5] = '{65, 308, 1'b0};
    tbl[6] = '{2048, THR, 1'b1};
    tbl[7] = '{127, 1, 1'b0};
    fill(0);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset valid", hv_valid, 0);
    chk_hv("reset query", query_hv, '0);
    @(negedge clk); nrst = 1;

    do_run(-1, -1, lat);
    chk("latency zeros", lat, 65);
    chk_hv("all zeros", query_hv, '0);
    handshake();

    fill(1);
    do_run(-1, -1, lat);
    chk("latency ones", lat, 65);
    chk_hv("all ones", query_hv, '1);
    handshake();

    fill(0);
    foreach (tbl[i]) for (int b = 0; b < tbl[i].ones; b++) arr[tbl[i].dim][b] = 1'b1;
    exp_hv = model();
    do_run(-1, -1, lat);
    chk("latency table", lat, 65);
    foreach (tbl[i]) chk($sformatf("thresh dim %0d", tbl[i].dim), query_hv[tbl[i].dim], tbl[i].exp);
    chk_hv("table model", query_hv, exp_hv);

    held = query_hv;
    fill(1);
    start = 1;
    repeat (10) begin
      @(negedge clk);
      chk("bp valid held", hv_valid, 1);
      chk("bp not busy", busy, 0);
      chk_hv("bp query held", query_hv, held);
    end
    start = 0;
    handshake();
    @(negedge clk);
    chk("idle after handshake", busy, 0);

    fill(2);
    exp_hv = model();
    do_run(30, -1, lat);
    chk("latency start poke", lat, 65);
    chk_hv("start poke query", query_hv, exp_hv);
    handshake();

    fill(0);
    do_run(-1, 40, lat);
    @(negedge clk); nrst = 1;
    repeat (3) @(negedge clk);
    chk("post abort idle", busy, 0);
    chk("post abort valid", hv_valid, 0);
    fill(1);
    do_run(-1, -1, lat);
    chk("latency after abort", lat, 65);
    chk_hv("after abort ones", query_hv, '1);
    handshake();

    fill(2);
    exp_hv = model();
    prev = 0;
    @(negedge clk);
    hv_ready = 1;
    start = 1;
    for (int v = 0; v < 20; v++) begin
      g = 0;
      while (!hv_valid && g < 300) begin
        @(negedge clk); g++;
      end
      chk("b2b valid", hv_valid, 1);
      chk_hv($sformatf("b2b query %0d", v), query_hv, exp_hv);
      if (v > 0) chk("b2b period", cyc - prev, 66);
      prev = cyc;
      if (v == 19) start = 0;
      else begin
        fill(2);
        exp_hv = model();
      end
      @(negedge clk);
    end
    hv_ready = 0;
    chk("b2b end valid", hv_valid, 0);
    chk("b2b end idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
